// File: rtl/aud_pkg.sv
// Shared audio definitions used by the player and recorder:
// default widths and the playback FSM state encoding.
package aud_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 20;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_SHIFT = 3'd2,
      S_NEXT  = 3'd3,
      S_PAUSE = 3'd4
   } aud_state_e;

endpackage

// File: rtl/aud_shift_out.sv
// Parallel-load, MSB-first serialiser with a bit counter.
// The serial bit is registered, so each bit appears one clock after it is shifted.
module aud_shift_out
   import aud_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_bit,
   output logic [CNT_W-1:0]  o_count
);

   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_count;
   logic              r_bit;

   // Any cycle that is not shifting drives a zero, which keeps the line quiet between words.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_shift <= '0;
         r_count <= '0;
         r_bit   <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_data;
         r_count <= '0;
         r_bit   <= 1'b0;
      end else if (i_shift) begin
         r_bit   <= r_shift[DATA_W-1];
         r_shift <= {r_shift[DATA_W-2:0], 1'b0};
         r_count <= r_count + CNT_W'(1);
      end else begin
         r_bit   <= 1'b0;
      end
   end

   assign o_bit   = r_bit;
   assign o_count = r_count;

endmodule

// File: rtl/aud_player.sv
// I2S left-channel playback from SRAM: one sample per LRC period, MSB one BCLK
// after the LRC falling edge, with pause/resume and abort.
module aud_player
   import aud_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_lrc,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_dacdat,
   output logic              o_finished
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   aud_state_e        r_state;
   logic              r_lrc_q;
   logic              r_pause;
   logic              r_finished;
   logic [ADDR_W-1:0] r_address;

   logic              w_lrc_fall;
   logic              w_word_done;
   logic              w_last;
   logic              w_load;
   logic              w_shift;
   logic              w_bit;
   logic [CNT_W-1:0]  w_count;

   assign w_lrc_fall  = r_lrc_q && !i_lrc;
   assign w_word_done = (r_state == S_SHIFT) && (w_count == CNT_W'(DATA_W));
   // The all-ones address is treated as final so the counter can never wrap.
   assign w_last      = (r_address == i_end_addr) || (&r_address);
   assign w_load      = !i_stop && (r_state == S_WAIT) && w_lrc_fall;
   assign w_shift     = !i_stop && (r_state == S_SHIFT) && !w_word_done;

   aud_shift_out #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shift_out (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_stop),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (i_sram_data),
      .o_bit   (w_bit),
      .o_count (w_count)
   );

   // Stop overrides everything; a pause request waits for the word in flight to finish.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_lrc_q    <= 1'b1;
         r_pause    <= 1'b0;
         r_finished <= 1'b0;
         r_address  <= '0;
      end else begin
         r_lrc_q    <= i_lrc;
         r_finished <= 1'b0;
         if (i_stop) begin
            r_state   <= S_IDLE;
            r_pause   <= 1'b0;
            r_address <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start && !i_pause) begin
                     r_state   <= S_WAIT;
                     r_address <= '0;
                  end
               end
               S_WAIT: begin
                  if (i_pause) r_pause <= 1'b1;
                  if (w_lrc_fall) r_state <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (w_word_done) begin
                     r_pause <= 1'b0;
                     if (w_last) begin
                        r_state    <= S_IDLE;
                        r_finished <= 1'b1;
                        r_address  <= '0;
                     end else begin
                        r_address <= r_address + ADDR_W'(1);
                        r_state   <= (r_pause || i_pause) ? S_PAUSE : S_NEXT;
                     end
                  end else if (i_pause) begin
                     r_pause <= 1'b1;
                  end
               end
               S_NEXT: begin
                  if (i_pause) r_pause <= 1'b1;
                  if (i_lrc) r_state <= S_WAIT;
               end
               S_PAUSE: begin
                  if (i_start && !i_pause) r_state <= S_NEXT;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_address  = r_address;
   assign o_dacdat   = w_bit;
   assign o_finished = r_finished;

endmodule

// File: tb/tb_aud_player.sv
// Directed bench for aud_player: LRC period of 64 BCLKs (32 low = left, 32 high),
// SRAM modelled as a small combinational array indexed by o_address.
module tb_aud_player;

   logic        i_clk;
   logic        i_rst;
   logic        i_lrc;
   logic        i_start;
   logic        i_pause;
   logic        i_stop;
   logic [19:0] i_end_addr;
   logic [15:0] i_sram_data;
   logic [19:0] o_address;
   logic        o_dacdat;
   logic        o_finished;

   logic [15:0] mem [0:3];
   int          vecCount;
   int          missCount;
   int          lrcCnt;
   int          finCount;

   aud_player #(
      .DATA_W (16),
      .ADDR_W (20)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_lrc       (i_lrc),
      .i_start     (i_start),
      .i_pause     (i_pause),
      .i_stop      (i_stop),
      .i_end_addr  (i_end_addr),
      .i_sram_data (i_sram_data),
      .o_address   (o_address),
      .o_dacdat    (o_dacdat),
      .o_finished  (o_finished)
   );

   assign i_sram_data = (o_address < 20'd4) ? mem[o_address[1:0]] : 16'h0000;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance to the next falling clock edge, then move the LRC pattern along
   // and tally any finished pulse visible in the cycle just completed.
   task automatic cycle();
      @(negedge i_clk);
      if (o_finished === 1'b1) finCount++;
      lrcCnt++;
      i_lrc = ((lrcCnt % 64) >= 32);
   endtask

   task automatic doReset();
      i_rst = 1'b1;
      cycle();
      cycle();
      i_rst = 1'b0;
   endtask

   task automatic pulseStart();
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic waitFall();
      while ((lrcCnt % 64) != 0) cycle();
   endtask

   // Called right after LRC has been driven low: returns the bit seen after the
   // load edge and then nBits serial bits collected MSB first.
   task automatic captureWord(input int nBits, output logic [15:0] w, output logic pre);
      cycle();
      pre = o_dacdat;
      w = 16'h0000;
      for (int n = 0; n < nBits; n++) begin
         cycle();
         w = {w[14:0], o_dacdat};
      end
   endtask

   task automatic waitQuiet(input int n, output int dacBad);
      dacBad = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (o_dacdat !== 1'b0) dacBad++;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      cycle();
      cycle();
      vecCount++;
      if (o_address !== 20'h0) begin
         missCount++;
         $display("[TB] FAIL reset_address: got %h expected %h", o_address, 20'h0);
      end
      vecCount++;
      if (o_dacdat !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_dacdat: got %b expected %b", o_dacdat, 1'b0);
      end
      vecCount++;
      if (o_finished !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_finished: got %b expected %b", o_finished, 1'b0);
      end
      i_rst = 1'b0;
   endtask

   task automatic test_two_words();
      logic [15:0] w;
      logic        pre;
      int          f0;
      doReset();
      i_end_addr = 20'd1;
      mem[0] = 16'hF2CF;
      mem[1] = 16'hF64F;
      f0 = finCount;
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (pre !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL two_pre_msb: got %b expected %b", pre, 1'b0);
      end
      vecCount++;
      if (w !== 16'hF2CF) begin
         missCount++;
         $display("[TB] FAIL two_word0: got %h expected %h", w, 16'hF2CF);
      end
      cycle();
      vecCount++;
      if (o_address !== 20'd1) begin
         missCount++;
         $display("[TB] FAIL two_addr_after_w0: got %h expected %h", o_address, 20'd1);
      end
      vecCount++;
      if (o_dacdat !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL two_dac_after_lsb: got %b expected %b", o_dacdat, 1'b0);
      end
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'hF64F) begin
         missCount++;
         $display("[TB] FAIL two_word1: got %h expected %h", w, 16'hF64F);
      end
      cycle();
      vecCount++;
      if (o_finished !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL two_finished: got %b expected %b", o_finished, 1'b1);
      end
      vecCount++;
      if (o_address !== 20'd0) begin
         missCount++;
         $display("[TB] FAIL two_addr_end: got %h expected %h", o_address, 20'd0);
      end
      cycle();
      vecCount++;
      if (finCount - f0 !== 1) begin
         missCount++;
         $display("[TB] FAIL two_fin_count: got %0d expected %0d", finCount - f0, 1);
      end
   endtask

   task automatic test_pause();
      logic [15:0] w;
      logic        pre;
      int          f0;
      int          bad;
      doReset();
      i_end_addr = 20'd1;
      mem[0] = 16'hF2CF;
      mem[1] = 16'hF64F;
      f0 = finCount;
      pulseStart();
      waitFall();
      cycle();
      w = 16'h0000;
      for (int n = 0; n < 16; n++) begin
         cycle();
         i_pause = 1'b0;
         w = {w[14:0], o_dacdat};
         if (n == 5) i_pause = 1'b1;
      end
      vecCount++;
      if (w !== 16'hF2CF) begin
         missCount++;
         $display("[TB] FAIL pause_word0: got %h expected %h", w, 16'hF2CF);
      end
      cycle();
      waitQuiet(192, bad);
      vecCount++;
      if (bad !== 0) begin
         missCount++;
         $display("[TB] FAIL pause_quiet: got %0d nonzero bits expected %0d", bad, 0);
      end
      vecCount++;
      if (o_address !== 20'd1) begin
         missCount++;
         $display("[TB] FAIL pause_addr_held: got %h expected %h", o_address, 20'd1);
      end
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'hF64F) begin
         missCount++;
         $display("[TB] FAIL pause_resume_word: got %h expected %h", w, 16'hF64F);
      end
      cycle();
      cycle();
      vecCount++;
      if (finCount - f0 !== 1) begin
         missCount++;
         $display("[TB] FAIL pause_fin_count: got %0d expected %0d", finCount - f0, 1);
      end
   endtask

   task automatic test_stop();
      logic [15:0] w;
      logic        pre;
      int          f0;
      int          bad;
      doReset();
      i_end_addr = 20'd1;
      mem[0] = 16'h1234;
      mem[1] = 16'h83C1;
      f0 = finCount;
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'h1234) begin
         missCount++;
         $display("[TB] FAIL stop_word0: got %h expected %h", w, 16'h1234);
      end
      waitFall();
      captureWord(9, w, pre);
      vecCount++;
      if (w[8:0] !== 9'h107) begin
         missCount++;
         $display("[TB] FAIL stop_partial: got %h expected %h", w[8:0], 9'h107);
      end
      i_stop = 1'b1;
      cycle();
      i_stop = 1'b0;
      vecCount++;
      if (o_dacdat !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL stop_dacdat: got %b expected %b", o_dacdat, 1'b0);
      end
      vecCount++;
      if (o_address !== 20'd0) begin
         missCount++;
         $display("[TB] FAIL stop_address: got %h expected %h", o_address, 20'd0);
      end
      waitQuiet(128, bad);
      vecCount++;
      if (bad !== 0) begin
         missCount++;
         $display("[TB] FAIL stop_quiet: got %0d nonzero bits expected %0d", bad, 0);
      end
      vecCount++;
      if (finCount - f0 !== 0) begin
         missCount++;
         $display("[TB] FAIL stop_no_finished: got %0d expected %0d", finCount - f0, 0);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] w;
      logic        pre;
      int          f0;
      int          bad;
      doReset();
      i_end_addr = 20'd1;
      mem[0] = 16'hF2CF;
      mem[1] = 16'hF64F;
      f0 = finCount;
      pulseStart();
      waitFall();
      captureWord(6, w, pre);
      vecCount++;
      if (w[5:0] !== 6'h3C) begin
         missCount++;
         $display("[TB] FAIL simul_partial: got %h expected %h", w[5:0], 6'h3C);
      end
      i_stop  = 1'b1;
      i_pause = 1'b1;
      i_start = 1'b1;
      cycle();
      i_stop  = 1'b0;
      i_pause = 1'b0;
      i_start = 1'b0;
      vecCount++;
      if (o_dacdat !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL simul_dacdat: got %b expected %b", o_dacdat, 1'b0);
      end
      waitQuiet(160, bad);
      vecCount++;
      if (bad !== 0 || finCount - f0 !== 0) begin
         missCount++;
         $display("[TB] FAIL simul_idle: got %0d bits %0d finished expected 0 and 0", bad, finCount - f0);
      end
   endtask

   task automatic test_single();
      logic [15:0] w;
      logic        pre;
      int          f0;
      int          bad;
      doReset();
      i_end_addr = 20'd0;
      mem[0] = 16'h6A4C;
      mem[1] = 16'hFFFF;
      f0 = finCount;
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'h6A4C) begin
         missCount++;
         $display("[TB] FAIL single_word: got %h expected %h", w, 16'h6A4C);
      end
      cycle();
      vecCount++;
      if (o_finished !== 1'b1 || o_address !== 20'd0) begin
         missCount++;
         $display("[TB] FAIL single_end: got fin=%b addr=%h expected fin=1 addr=0", o_finished, o_address);
      end
      waitQuiet(160, bad);
      vecCount++;
      if (bad !== 0 || finCount - f0 !== 1) begin
         missCount++;
         $display("[TB] FAIL single_after: got %0d bits %0d finished expected 0 and 1", bad, finCount - f0);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      logic        pre;
      int          f0;
      int          bad;
      doReset();
      i_end_addr = 20'd1;
      mem[0] = 16'hF2CF;
      mem[1] = 16'hF64F;
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      waitFall();
      captureWord(6, w, pre);
      f0 = finCount;
      i_rst = 1'b1;
      cycle();
      cycle();
      vecCount++;
      if (o_dacdat !== 1'b0 || o_address !== 20'd0 || o_finished !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL rstmid_outputs: got dac=%b addr=%h fin=%b expected all 0", o_dacdat, o_address, o_finished);
      end
      i_rst = 1'b0;
      waitQuiet(128, bad);
      vecCount++;
      if (bad !== 0 || finCount - f0 !== 0) begin
         missCount++;
         $display("[TB] FAIL rstmid_quiet: got %0d bits %0d finished expected 0 and 0", bad, finCount - f0);
      end
      pulseStart();
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'hF2CF) begin
         missCount++;
         $display("[TB] FAIL rstmid_word0: got %h expected %h", w, 16'hF2CF);
      end
      waitFall();
      captureWord(16, w, pre);
      vecCount++;
      if (w !== 16'hF64F) begin
         missCount++;
         $display("[TB] FAIL rstmid_word1: got %h expected %h", w, 16'hF64F);
      end
      cycle();
      vecCount++;
      if (o_finished !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL rstmid_finished: got %b expected %b", o_finished, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      logic [15:0] expw [0:2];
      logic        pre;
      int          f0;
      doReset();
      expw[0] = 16'hA5A5;
      expw[1] = 16'h3C3C;
      expw[2] = 16'h0FF0;
      for (int i = 0; i < 3; i++) mem[i] = expw[i];
      mem[3] = 16'hFFFF;
      i_end_addr = 20'd2;
      f0 = finCount;
      pulseStart();
      for (int i = 0; i < 3; i++) begin
         waitFall();
         captureWord(16, w, pre);
         vecCount++;
         if (w !== expw[i]) begin
            missCount++;
            $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, w, expw[i]);
         end
      end
      cycle();
      vecCount++;
      if (o_address !== 20'd0 || o_finished !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL b2b_end: got addr=%h fin=%b expected addr=0 fin=1", o_address, o_finished);
      end
      cycle();
      vecCount++;
      if (finCount - f0 !== 1) begin
         missCount++;
         $display("[TB] FAIL b2b_fin_count: got %0d expected %0d", finCount - f0, 1);
      end
   endtask

   initial begin
      vecCount   = 0;
      missCount  = 0;
      lrcCnt     = 0;
      finCount   = 0;
      i_rst      = 1'b1;
      i_lrc      = 1'b0;
      i_start    = 1'b0;
      i_pause    = 1'b0;
      i_stop     = 1'b0;
      i_end_addr = 20'd0;
      for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
      test_reset();
      test_two_words();
      test_pause();
      test_stop();
      test_simultaneous();
      test_single();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
